// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch / load-store memory arbiter.
// Holds width and starvation-guard defaults plus the arbiter state encoding.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_D  = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_arb_age_cnt.sv
// Saturating age counter: counts data grants made while fetch is waiting and
// flags when fetch must win the next arbitration.
module mem_arb_age_cnt
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] cnt;

  assign at_max = (cnt >= CNT_W'(STARVE_MAX));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one multi-cycle memory between instruction fetch and load/store.
// Optional fetch starvation guard compiled in with `define MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // fetch requester
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  // load/store requester
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_ack_o,
  output logic [DATA_W-1:0] d_rdata_o,
  // shared memory
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  // pipeline freeze
  output logic              stall_o
);

  if (STARVE_MAX == 0) begin : g_bad_starve_max
    $error("mem_arbiter: STARVE_MAX must be at least 1");
  end

  arb_state_e state;
  logic       force_fetch;
  logic       take_d;
  logic       take_if;

  // Data wins unless the guard says fetch has waited long enough.
  always_comb begin
    take_d  = 1'b0;
    take_if = 1'b0;
    if (if_req_i && force_fetch) begin
      take_if = 1'b1;
    end else if (d_req_i) begin
      take_d = 1'b1;
    end else if (if_req_i) begin
      take_if = 1'b1;
    end
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic age_inc;
  logic age_clr;

  assign age_inc = (state == IDLE) && take_d && if_req_i;
  assign age_clr = (state == IDLE) && (take_if || !if_req_i);

  mem_arb_age_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_age_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc    (age_inc),
    .clr    (age_clr),
    .at_max (force_fetch)
  );
`else
  assign force_fetch = 1'b0;
`endif

  assign stall_o = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_ack_o    <= 1'b0;
      d_ack_o     <= 1'b0;
      if_rdata_o  <= '0;
      d_rdata_o   <= '0;
    end else begin
      if_ack_o <= 1'b0;
      d_ack_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (take_d) begin
            state       <= GNT_D;
            mem_req_o   <= 1'b1;
            mem_we_o    <= d_we_i;
            mem_addr_o  <= d_addr_i;
            mem_wdata_o <= d_wdata_i;
          end else if (take_if) begin
            state       <= GNT_IF;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= if_addr_i;
            mem_wdata_o <= '0;
          end
        end
        GNT_IF, GNT_D: begin
          // Ack is registered here so it lands in RESP, one cycle after mem_ack_i.
          if (mem_ack_i) begin
            state     <= RESP;
            mem_req_o <= 1'b0;
            if (state == GNT_D) begin
              d_ack_o <= 1'b1;
              if (!mem_we_o) d_rdata_o <= mem_rdata_i;
            end else begin
              if_ack_o   <= 1'b1;
              if_rdata_o <= mem_rdata_i;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; inputs and checks on the falling edge.
module tb_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i = 1'b0;
  logic        d_we_i = 1'b0;
  logic [31:0] d_addr_i = '0;
  logic [31:0] d_wdata_i = '0;
  logic        d_ack_o;
  logic [31:0] d_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ack_i = 1'b0;
  logic        stall_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (4)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_ack_o    (if_ack_o),
    .if_rdata_o  (if_rdata_o),
    .d_req_i     (d_req_i),
    .d_we_i      (d_we_i),
    .d_addr_i    (d_addr_i),
    .d_wdata_i   (d_wdata_i),
    .d_ack_o     (d_ack_o),
    .d_rdata_o   (d_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i),
    .stall_o     (stall_o)
  );

  task automatic cyc();
    @(negedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    cyc();
    n_cmp++; if ({mem_req_o, mem_we_o, if_ack_o, d_ack_o, stall_o} !== 5'b0) begin n_bad++;
      $display("FAIL reset_ctrl: got %b want 00000", {mem_req_o, mem_we_o, if_ack_o, d_ack_o, stall_o}); end
    n_cmp++; if ({mem_addr_o, mem_wdata_o} !== 64'h0) begin n_bad++;
      $display("FAIL reset_addr_wdata: got %h want 0", {mem_addr_o, mem_wdata_o}); end
    n_cmp++; if ({if_rdata_o, d_rdata_o} !== 64'h0) begin n_bad++;
      $display("FAIL reset_rdata: got %h want 0", {if_rdata_o, d_rdata_o}); end
    rst_i = 1'b1;
    cyc();
  endtask

  task automatic test_fetch_read();
    if_req_i = 1'b1; if_addr_i = 32'h10; #1;
    n_cmp++; if ({stall_o, mem_req_o} !== 2'b10) begin n_bad++;
      $display("FAIL fetch_c0: got stall,req=%b want 10", {stall_o, mem_req_o}); end
    for (int unsigned c = 1; c <= 3; c++) begin
      cyc();
      if (c == 3) begin mem_ack_i = 1'b1; mem_rdata_i = 32'h8C020004; end
      n_cmp++; if ({mem_req_o, mem_we_o, if_ack_o} !== 3'b100 || mem_addr_o !== 32'h10) begin n_bad++;
        $display("FAIL fetch_c%0d: got req,we,ack=%b addr=%h want 100 addr=10", c, {mem_req_o, mem_we_o, if_ack_o}, mem_addr_o); end
    end
    cyc();
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0BADF00D;
    n_cmp++; if ({if_ack_o, d_ack_o, mem_req_o} !== 3'b100 || if_rdata_o !== 32'h8C020004) begin n_bad++;
      $display("FAIL fetch_ack: got acks,req=%b rdata=%h want 100 rdata=8c020004", {if_ack_o, d_ack_o, mem_req_o}, if_rdata_o); end
    if_req_i = 1'b0;
    cyc();
    n_cmp++; if ({if_ack_o, mem_req_o} !== 2'b00 || if_rdata_o !== 32'h8C020004) begin n_bad++;
      $display("FAIL fetch_after: got ack,req=%b rdata=%h want 00 rdata=8c020004", {if_ack_o, mem_req_o}, if_rdata_o); end
  endtask

  task automatic test_data_write();
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h20; d_wdata_i = 32'hDEADBEEF;
    cyc();
    n_cmp++; if ({mem_req_o, mem_we_o} !== 2'b11 || mem_wdata_o !== 32'hDEADBEEF || mem_addr_o !== 32'h20) begin n_bad++;
      $display("FAIL write_issue: got req,we=%b wdata=%h addr=%h want 11 deadbeef 20", {mem_req_o, mem_we_o}, mem_wdata_o, mem_addr_o); end
    mem_ack_i = 1'b1; mem_rdata_i = 32'h12345678;
    cyc();
    mem_ack_i = 1'b0;
    n_cmp++; if (d_ack_o !== 1'b1 || d_rdata_o !== 32'h0 || if_rdata_o !== 32'h8C020004) begin n_bad++;
      $display("FAIL write_ack: got ack=%b d_rdata=%h if_rdata=%h want 1 0 8c020004", d_ack_o, d_rdata_o, if_rdata_o); end
    d_req_i = 1'b0; d_we_i = 1'b0;
    cyc();
    n_cmp++; if ({d_ack_o, mem_req_o} !== 2'b00) begin n_bad++;
      $display("FAIL write_pulse: got ack,req=%b want 00", {d_ack_o, mem_req_o}); end
  endtask

  task automatic test_simultaneous();
    if_req_i = 1'b1; if_addr_i = 32'h40;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h80;
    cyc();
    n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h80 || stall_o !== 1'b1) begin n_bad++;
      $display("FAIL simul_c1: got req=%b addr=%h stall=%b want 1 80 1", mem_req_o, mem_addr_o, stall_o); end
    mem_ack_i = 1'b1; mem_rdata_i = 32'hA5A50001;
    cyc();
    mem_ack_i = 1'b0;
    n_cmp++; if ({d_ack_o, if_ack_o, stall_o} !== 3'b101 || d_rdata_o !== 32'hA5A50001) begin n_bad++;
      $display("FAIL simul_c2: got dack,iack,stall=%b d_rdata=%h want 101 a5a50001", {d_ack_o, if_ack_o, stall_o}, d_rdata_o); end
    d_req_i = 1'b0;
    cyc();
    n_cmp++; if ({mem_req_o, stall_o} !== 2'b01) begin n_bad++;
      $display("FAIL simul_c3: got req,stall=%b want 01", {mem_req_o, stall_o}); end
    cyc();
    n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h40 || stall_o !== 1'b1) begin n_bad++;
      $display("FAIL simul_c4: got req=%b addr=%h stall=%b want 1 40 1", mem_req_o, mem_addr_o, stall_o); end
    mem_ack_i = 1'b1; mem_rdata_i = 32'h5A5A0002;
    cyc();
    mem_ack_i = 1'b0;
    n_cmp++; if ({if_ack_o, stall_o} !== 2'b10 || if_rdata_o !== 32'h5A5A0002) begin n_bad++;
      $display("FAIL simul_c5: got iack,stall=%b if_rdata=%h want 10 5a5a0002", {if_ack_o, stall_o}, if_rdata_o); end
    if_req_i = 1'b0;
    cyc();
  endtask

  task automatic test_spurious_ack();
    mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF0000;
    cyc();
    n_cmp++; if ({mem_req_o, if_ack_o, d_ack_o} !== 3'b000) begin n_bad++;
      $display("FAIL spur_idle: got req,iack,dack=%b want 000", {mem_req_o, if_ack_o, d_ack_o}); end
    mem_ack_i = 1'b0;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h30;
    cyc();
    mem_ack_i = 1'b1; mem_rdata_i = 32'h11110000;
    cyc();
    mem_rdata_i = 32'h22220000;
    n_cmp++; if (d_ack_o !== 1'b1 || d_rdata_o !== 32'h11110000) begin n_bad++;
      $display("FAIL spur_read: got ack=%b rdata=%h want 1 11110000", d_ack_o, d_rdata_o); end
    d_req_i = 1'b0;
    cyc();
    mem_ack_i = 1'b0;
    n_cmp++; if ({mem_req_o, d_ack_o, if_ack_o} !== 3'b000 || d_rdata_o !== 32'h11110000) begin n_bad++;
      $display("FAIL spur_resp: got req,dack,iack=%b rdata=%h want 000 11110000", {mem_req_o, d_ack_o, if_ack_o}, d_rdata_o); end
    cyc();
  endtask

  task automatic test_reset_mid();
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h50; d_wdata_i = 32'h77;
    cyc();
    cyc();
    n_cmp++; if (mem_req_o !== 1'b1) begin n_bad++;
      $display("FAIL rstmid_pre: got req=%b want 1", mem_req_o); end
    rst_i = 1'b0; #1;
    n_cmp++; if ({mem_req_o, d_ack_o} !== 2'b00 || mem_addr_o !== 32'h0 || d_rdata_o !== 32'h0) begin n_bad++;
      $display("FAIL rstmid_async: got req,ack=%b addr=%h rdata=%h want 00 0 0", {mem_req_o, d_ack_o}, mem_addr_o, d_rdata_o); end
    cyc();
    rst_i = 1'b1;
    n_cmp++; if ({mem_req_o, d_ack_o} !== 2'b00) begin n_bad++;
      $display("FAIL rstmid_release: got req,ack=%b want 00", {mem_req_o, d_ack_o}); end
    cyc();
    n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h50 || d_ack_o !== 1'b0) begin n_bad++;
      $display("FAIL rstmid_regrant: got req=%b addr=%h ack=%b want 1 50 0", mem_req_o, mem_addr_o, d_ack_o); end
    mem_ack_i = 1'b1;
    cyc();
    mem_ack_i = 1'b0;
    n_cmp++; if (d_ack_o !== 1'b1) begin n_bad++;
      $display("FAIL rstmid_ack: got ack=%b want 1", d_ack_o); end
    d_req_i = 1'b0; d_we_i = 1'b0;
    cyc();
  endtask

  task automatic test_starvation();
    int d_cnt   = 0;
    int d_at_if = -1;
    bit seen_if = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h60;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h90;
    for (int unsigned c = 0; c < 40; c++) begin
      cyc();
      if (if_ack_o && !seen_if) begin seen_if = 1'b1; d_at_if = d_cnt; end
      if (d_ack_o && !seen_if) d_cnt++;
      mem_ack_i = mem_req_o;
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    n_cmp++; if (seen_if !== 1'b1 || d_at_if != 4) begin n_bad++;
      $display("FAIL starve_guard: got fetch_acked=%b data_grants_before=%0d want 1 4", seen_if, d_at_if); end
`else
    n_cmp++; if (seen_if !== 1'b0 || d_cnt < 8) begin n_bad++;
      $display("FAIL starve_strict: got fetch_acked=%b data_grants=%0d want 0 >=8", seen_if, d_cnt); end
`endif
    if_req_i = 1'b0; d_req_i = 1'b0;
    for (int unsigned c = 0; c < 5; c++) begin
      cyc();
      mem_ack_i = mem_req_o;
    end
    mem_ack_i = 1'b0;
    cyc();
    n_cmp++; if ({mem_req_o, stall_o} !== 2'b00) begin n_bad++;
      $display("FAIL starve_drain: got req,stall=%b want 00", {mem_req_o, stall_o}); end
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_data_write();
    test_simultaneous();
    test_spurious_ack();
    test_reset_mid();
    test_starvation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
